// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: access sizes, FSM states and the fetch NOP.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LS_WAIT = 2'd1;
    localparam logic [1:0] ST_IF_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // The unused encoding 11 is handled like a word access.
    function automatic logic is_misaligned(input logic [1:0] mem_type, input logic [1:0] off);
        case (mem_type)
            MEM_B:   return 1'b0;
            MEM_H:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_ls_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module mem_bus_arbiter_ls_align
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_type,
    input  logic        ld_sign,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be         = 4'b1111;
        wdata_lane = st_wdata;
        case (st_type)
            MEM_B: begin
                be         = 4'b0001 << st_off;
                wdata_lane = {4{st_wdata[7:0]}};
            end
            MEM_H: begin
                be         = 4'b0011 << st_off;
                wdata_lane = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // ld_sign set means LBU/LHU, so the fill bit is forced to zero.
    always_comb begin
        byte_sel  = rdata[{ld_off, 3'b000} +: 8];
        half_sel  = rdata[{ld_off[1], 4'b0000} +: 16];
        rdata_ext = rdata;
        case (ld_type)
            MEM_B:   rdata_ext = {{24{~ld_sign & byte_sel[7]}}, byte_sel};
            MEM_H:   rdata_ext = {{16{~ld_sign & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port bus arbiter between instruction fetch and load/store, with timeout and stall.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        ls_rmem,
    input  logic        ls_wmem,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [1:0]  ls_mem_type,
    input  logic        ls_mem_sign,
    output logic [31:0] ls_rdata,
    output logic        ls_ack,
    output logic        ls_err,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        drop;
    logic [1:0]  ld_off;
    logic [1:0]  ld_type;
    logic        ld_sign;
    logic        ls_req;
    logic        misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_lane;
    logic [31:0] ld_ext;

    assign ls_req     = ls_rmem | ls_wmem;
    assign misaligned = is_misaligned(ls_mem_type, ls_addr[1:0]);
    assign stall      = ls_req & ~ls_ack;

    mem_bus_arbiter_ls_align u_align (
        .st_off     (ls_addr[1:0]),
        .st_type    (ls_mem_type),
        .st_wdata   (ls_wdata),
        .be         (st_be),
        .wdata_lane (st_lane),
        .ld_off     (ld_off),
        .ld_type    (ld_type),
        .ld_sign    (ld_sign),
        .rdata      (bus_rdata),
        .rdata_ext  (ld_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            drop      <= 1'b0;
            ld_off    <= '0;
            ld_type   <= '0;
            ld_sign   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            if_ack    <= 1'b0;
            ls_rdata  <= '0;
            ls_ack    <= 1'b0;
            ls_err    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            ls_ack <= 1'b0;
            ls_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ls_req) begin
                        if (misaligned) begin
                            ls_ack   <= 1'b1;
                            ls_err   <= 1'b1;
                            ls_rdata <= '0;
                            state    <= ST_RESP;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= ls_wmem;
                            bus_addr  <= ls_addr & 32'hFFFF_FFFC;
                            bus_be    <= st_be;
                            bus_wdata <= st_lane;
                            ld_off    <= ls_addr[1:0];
                            ld_type   <= ls_mem_type;
                            ld_sign   <= ls_mem_sign;
                            cnt       <= '0;
                            state     <= ST_LS_WAIT;
                        end
                    end else if (if_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= if_addr & 32'hFFFF_FFFC;
                        bus_be    <= 4'b1111;
                        bus_wdata <= '0;
                        drop      <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_IF_WAIT;
                    end
                end
                ST_LS_WAIT: begin
                    if (bus_ready) begin
                        bus_req  <= 1'b0;
                        ls_ack   <= 1'b1;
                        ls_rdata <= bus_we ? 32'h0 : ld_ext;
                        state    <= ST_RESP;
                    end else if (cnt == TIMEOUT_CNT) begin
                        bus_req  <= 1'b0;
                        ls_ack   <= 1'b1;
                        ls_err   <= 1'b1;
                        ls_rdata <= '0;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_IF_WAIT: begin
                    drop <= drop | if_flush;
                    // A flush landing on the completing cycle must also swallow the ack.
                    if (bus_ready || cnt == TIMEOUT_CNT) begin
                        bus_req  <= 1'b0;
                        if_ack   <= ~(drop | if_flush);
                        if_rdata <= bus_ready ? bus_rdata : NOP_INSN;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    drop  <= drop | if_flush;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized checks of mem_bus_arbiter against a behavioural access model.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        ls_rmem, ls_wmem, ls_mem_sign, ls_ack, ls_err, stall;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [1:0]  ls_mem_type;
    logic        bus_req, bus_we, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .ls_rmem(ls_rmem), .ls_wmem(ls_wmem), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_mem_type(ls_mem_type), .ls_mem_sign(ls_mem_sign),
        .ls_rdata(ls_rdata), .ls_ack(ls_ack), .ls_err(ls_err), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access model: sizes in bytes, offsets and lane masks by plain arithmetic.
    function automatic int m_size(input logic [1:0] mt);
        return (mt == 2'd0) ? 1 : (mt == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [1:0] mt, input logic [31:0] a);
        return (a % m_size(mt)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] mt, input logic [31:0] a);
        int mask;
        mask = (1 << m_size(mt)) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] mt, input logic [31:0] wd);
        if (m_size(mt) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (m_size(mt) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] mt, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        if (m_size(mt) == 1) begin
            v = v & 32'hFF;
            if (!sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (m_size(mt) == 2) begin
            v = v & 32'hFFFF;
            if (!sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // delay: bus_ready comes on that bus_req cycle (0-based); negative means never.
    task automatic do_ls(input bit wr, input logic [31:0] a, input logic [1:0] mt,
                         input logic sgn, input logic [31:0] wd, input logic [31:0] rd,
                         input int delay);
        bit timed_out;
        int waitn;
        timed_out = (delay < 0) || (delay > TO);
        ls_rmem = !wr; ls_wmem = wr; ls_addr = a; ls_mem_type = mt;
        ls_mem_sign = sgn; ls_wdata = wd;
        tick;
        if (m_mis(mt, a)) begin
            check("mis_bus_req", bus_req, 1'b0);
            check("mis_ack", ls_ack, 1'b1);
            check("mis_err", ls_err, 1'b1);
            check("mis_rdata", ls_rdata, 32'h0);
        end else begin
            check("ls_bus_req", bus_req, 1'b1);
            check("ls_bus_we", bus_we, wr);
            check("ls_bus_addr", bus_addr, a & 32'hFFFF_FFFC);
            check("ls_bus_be", bus_be, m_be(mt, a));
            if (wr) check("ls_bus_wdata", bus_wdata, m_wdata(mt, wd));
            waitn = 0;
            while (bus_req === 1'b1 && waitn < 64) begin
                check("ls_stall", stall, 1'b1);
                bus_ready = (waitn == delay);
                bus_rdata = rd;
                tick;
                waitn++;
            end
            bus_ready = 1'b0;
            check("ls_wait_cycles", waitn, timed_out ? TO + 1 : delay + 1);
            check("ls_ack", ls_ack, 1'b1);
            check("ls_err", ls_err, timed_out);
            check("ls_rdata", ls_rdata, (timed_out || wr) ? 32'h0 : m_load(mt, sgn, a, rd));
            check("ls_stall_at_ack", stall, 1'b0);
        end
        ls_rmem = 1'b0; ls_wmem = 1'b0;
        tick;
        check("ls_ack_pulse", ls_ack, 1'b0);
        check("ls_idle_bus_req", bus_req, 1'b0);
    endtask

    task automatic do_if(input logic [31:0] a, input logic [31:0] rd,
                         input int delay, input int flush_at);
        bit timed_out, flushed;
        int waitn;
        timed_out = (delay < 0) || (delay > TO);
        flushed = 1'b0;
        if_req = 1'b1; if_addr = a;
        tick;
        check("if_bus_req", bus_req, 1'b1);
        check("if_bus_addr", bus_addr, a);
        check("if_bus_we", bus_we, 1'b0);
        check("if_bus_be", bus_be, 4'hF);
        waitn = 0;
        while (bus_req === 1'b1 && waitn < 64) begin
            if_flush = (waitn == flush_at);
            if (waitn == flush_at) begin
                if_req = 1'b0;
                flushed = 1'b1;
            end
            bus_ready = (waitn == delay);
            bus_rdata = rd;
            tick;
            waitn++;
        end
        if_flush = 1'b0; bus_ready = 1'b0;
        check("if_wait_cycles", waitn, timed_out ? TO + 1 : delay + 1);
        check("if_ack", if_ack, !flushed);
        if (!flushed) check("if_rdata", if_rdata, timed_out ? 32'h0000_0013 : rd);
        if_req = 1'b0;
        tick;
        check("if_ack_pulse", if_ack, 1'b0);
        check("if_idle_bus_req", bus_req, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; if_flush = 0;
        ls_rmem = 0; ls_wmem = 0; ls_addr = 0; ls_wdata = 0; ls_mem_type = 0; ls_mem_sign = 0;
        bus_rdata = 0; bus_ready = 0;
        #12;
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", bus_be, 4'h0);
        check("rst_acks", {if_ack, ls_ack, ls_err, bus_we, stall}, 5'b0);
        check("rst_rdata", if_rdata | ls_rdata | bus_wdata, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        // Signed byte load from the top lane.
        do_ls(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 32'h80AA_BBCC, 0);
        check("byte_load_value", ls_rdata, 32'hFFFF_FF80);
        // Half store to the upper lanes.
        do_ls(1'b1, 32'h202, 2'b01, 1'b0, 32'h1234_ABCD, 32'h0, 0);
        check("half_store_be", bus_be, 4'b1100);
        check("half_store_wdata", bus_wdata, 32'hABCD_ABCD);

        // Fetch and load requested together: the load is served first.
        if_req = 1'b1; if_addr = 32'h400;
        ls_rmem = 1'b1; ls_addr = 32'h10; ls_mem_type = 2'b10; ls_mem_sign = 1'b0;
        tick;
        check("prio_bus_addr", bus_addr, 32'h10);
        check("prio_stall", stall, 1'b1);
        bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick;
        bus_ready = 1'b0;
        check("prio_ls_ack", ls_ack, 1'b1);
        check("prio_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
        check("prio_no_if_ack", if_ack, 1'b0);
        ls_rmem = 1'b0;
        tick;
        check("prio_idle_gap", bus_req, 1'b0);
        tick;
        check("prio_if_bus_req", bus_req, 1'b1);
        check("prio_if_bus_addr", bus_addr, 32'h400);
        bus_ready = 1'b1; bus_rdata = 32'h0010_0093;
        tick;
        bus_ready = 1'b0;
        check("prio_if_ack", if_ack, 1'b1);
        check("prio_if_rdata", if_rdata, 32'h0010_0093);
        if_req = 1'b0;
        tick;

        // Misaligned word, illegal type treated as word, timeout edges.
        do_ls(1'b0, 32'h2, 2'b10, 1'b0, 32'h0, 32'h0, 0);
        do_ls(1'b0, 32'h6, 2'b11, 1'b0, 32'h0, 32'h0, 0);
        do_ls(1'b0, 32'h8, 2'b11, 1'b0, 32'h0, 32'h1357_9BDF, 1);
        do_if(32'h500, 32'h0, -1, -1);
        do_if(32'h504, 32'h1111_2222, TO, -1);
        do_if(32'h508, 32'h3333_4444, 2, 1);
        do_if(32'h50C, 32'h5555_6666, 0, 0);
        do_ls(1'b0, 32'h7E, 2'b01, 1'b1, 32'h0, 32'h8001_7FFF, -1);
        do_ls(1'b0, 32'h7E, 2'b01, 1'b1, 32'h0, 32'h8001_7FFF, TO);

        // Asynchronous reset while a load waits on the bus.
        ls_rmem = 1'b1; ls_addr = 32'h20; ls_mem_type = 2'b10;
        tick;
        check("rst_mid_bus_req_before", bus_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_bus_req", bus_req, 1'b0);
        check("rst_mid_bus_addr", bus_addr, 32'h0);
        check("rst_mid_bus_be", bus_be, 4'h0);
        ls_rmem = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick;
        do_ls(1'b0, 32'h21, 2'b00, 1'b1, 32'h0, 32'h0000_F700, 0);

        // Randomized mix of loads, stores and fetches.
        for (int i = 0; i < 80; i++) begin
            int kind, r, dly;
            logic [31:0] a, d, w;
            kind = $urandom_range(0, 2);
            a = $urandom; d = $urandom; w = $urandom;
            r = $urandom_range(0, 9);
            dly = (r < 7) ? (r % 3) : ((r == 7) ? TO : -1);
            if (kind == 2) begin
                do_if(a & 32'hFFFF_FFFC, d, dly, ($urandom_range(0, 5) == 0) ? 0 : -1);
            end else begin
                if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
                do_ls(kind == 1, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w, d, dly);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the core's single-port memory bus between instruction fetch (IF) and the load/store path driven by the decoded rmem/wmem/mem_type/mem_sign controls. Load/store has priority; fetch is held off while a data access is outstanding. The block handles byte-lane steering, load sign or zero extension, misaligned-access rejection and a bus timeout, and it drives the pipeline stall. It sits between the IF stage, the EX/MEM stage and the external bus.

## Interface
- TIMEOUT, default 255: max cycles waiting for bus_ready before abort; 8-bit counter.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch address, word aligned.
- if_flush  in  1  discard the in-flight fetch response.
- if_rdata  out  32  fetched instruction; valid with if_ack.
- if_ack  out  1  one-cycle fetch completion pulse.
- ls_rmem  in  1  load request; held until ls_ack.
- ls_wmem  in  1  store request; held until ls_ack. Never asserted together with ls_rmem.
- ls_addr  in  32  data byte address.
- ls_wdata  in  32  store data, right-justified.
- ls_mem_type  in  2  00 byte, 01 half, 10 word. 11 is illegal and treated as word.
- ls_mem_sign  in  1  func3[2]; 1 means zero-extend (LBU/LHU).
- ls_rdata  out  32  extended load data; valid with ls_ack.
- ls_ack  out  1  one-cycle load/store completion pulse.
- ls_err  out  1  with ls_ack: misaligned or timed out.
- stall  out  1  hold the pipeline; equals (ls_rmem|ls_wmem) & ~ls_ack.
- bus_req  out  1  bus request; held until bus_ready is sampled.
- bus_we  out  1  write.
- bus_addr  out  32  word-aligned address, low two bits zero.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-steered store data.
- bus_rdata  in  32  read data; valid with bus_ready.
- bus_ready  in  1  transfer completes this cycle.

## Operation
- FSM states: IDLE, LS_WAIT, IF_WAIT, RESP.
- IDLE:
  - ls_rmem|ls_wmem and aligned: latch the access and go to LS_WAIT.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]≠0): go to RESP with ls_err=1. No bus cycle is issued.
  - Else if_req: latch if_addr, clear the drop flag, go to IF_WAIT.
- LS_WAIT / IF_WAIT:
  - bus_req=1 and all bus outputs come from the latched registers.
  - bus_ready high: capture bus_rdata and go to RESP.
  - Timeout counter reaches TIMEOUT: go to RESP with err=1 and rdata=0.
- RESP: pulse the ack for the owner, then return to IDLE.
  - Fetch: if_ack is suppressed if the drop flag is set.
  - Timeout on a fetch: if_ack with if_rdata=0x00000013 (NOP).
- if_flush in IF_WAIT or RESP sets the drop flag. The bus transfer still completes.
- Byte enables and store steering (off = addr[1:0]):
  - Byte: be=0001<<off, wdata = {4{wdata[7:0]}}.
  - Half: be=0011<<off, wdata = {2{wdata[15:0]}}.
  - Word: be=1111, wdata unchanged.
- Load extraction: select the byte or half at the offset, then sign-extend unless ls_mem_sign=1.
- Stores return ls_rdata=0.
- Priority: load/store always wins in IDLE, so fetch can starve under continuous data traffic (accepted).

## Timing
- Reset values: FSM in IDLE; bus_req, bus_we, if_ack, ls_ack, ls_err all 0; bus_addr, bus_be, bus_wdata, if_rdata, ls_rdata all 0; counter 0, drop flag 0.
- All outputs are registered except stall.
- Request sampled in IDLE at cycle N:
  - bus_req is high from N+1.
  - bus_ready at N+1 gives the ack at N+2 and IDLE at N+3.
  - Minimum latency is 2 cycles; throughput is one access per 3 cycles.
- Misaligned access: ls_ack and ls_err both at N+1.
- Timeout: the counter increments each WAIT cycle without bus_ready. Abort at count = TIMEOUT, ack on the next cycle.
- bus_ready in the same cycle the count hits TIMEOUT: the transfer succeeds.
- Changing request inputs while not in IDLE has no effect.
- Reset mid-transfer drops bus_req immediately; the bus must tolerate the abandoned cycle.

## Structure
- The shared defines header gets:
  - mem_type encodings (MEM_B, MEM_H, MEM_W);
  - FSM state encodings (2-bit);
  - NOP constant 0x00000013.
- Sub-module ls_align (combinational): computes be/wdata steering from (addr[1:0], mem_type, wdata) and load extraction from (addr[1:0], mem_type, mem_sign, rdata). Instantiated once.

## Test plan
- Byte load, addr 0x103, mem_sign=0, bus_rdata 0x80AABBCC, bus_ready 1 cycle after bus_req: bus_addr=0x100, be=1000, ls_rdata=0xFFFFFF80 at N+2.
- Half store, addr 0x202, wdata 0x1234ABCD: bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, ls_ack with ls_err=0.
- if_req and ls_rmem both high in IDLE: the load is served first and stall=1 until ls_ack. The fetch bus_req follows on the cycle after the load's RESP.
- Word load at 0x2: ls_ack=ls_err=1 at N+1, bus_req never asserted.
- Fetch with bus_ready never asserted, TIMEOUT=4: if_ack with if_rdata=0x00000013 after the timeout. A fetch with if_flush during IF_WAIT produces no if_ack.
- rst_n dropped while in LS_WAIT: bus_req=0 asynchronously and all outputs are 0. The first request after release starts cleanly from IDLE.
